// File: rtl/es_ordered_bs_mul_nch.sv
// es_ordered_bs_mul_nch: multi-lane bitstream multiplier counting AND (or XNOR with ES_BS_BIPOLAR_EN) of ordered comparator streams.
module es_ordered_bs_mul_nch #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int NUM_LANES = 4,
  parameter int WXIP1 = DATA_WIDTH*NUM_INPUTS+1
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
`ifdef ES_BS_BIPOLAR_EN
  input  logic bipolar,
`endif
  input  logic [NUM_LANES-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in,
  output logic [NUM_LANES-1:0][WXIP1-1:0] bin_data_out,
  output logic busy,
  output logic done
);
  localparam int CW = DATA_WIDTH*NUM_INPUTS;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [NUM_LANES-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] x;
  logic [NUM_LANES-1:0] lane_bit;
  logic launch, bip;
  assign launch = en && start && state != RUN;
`ifdef ES_BS_BIPOLAR_EN
  always_ff @(posedge clk)
    if (rst) bip <= 1'b0;
    else if (launch) bip <= bipolar;
`else
  assign bip = 1'b0;
`endif
  // Each digit of the counter drives one operand's comparator, so a full count enumerates every bit tuple once.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [NUM_INPUTS-1:0] s;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
      assign s[i] = cnt[i*DATA_WIDTH +: DATA_WIDTH] < x[l][i];
    end
    assign lane_bit[l] = bip ? ~^s : &s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      x <= '0;
      bin_data_out <= '0;
    end else if (launch) begin
      state <= RUN;
      cnt <= '0;
      x <= bin_data_in;
      bin_data_out <= '0;
    end else if (en && state == RUN) begin
      cnt <= cnt + 1'b1;
      for (int l = 0; l < NUM_LANES; l++) bin_data_out[l] <= bin_data_out[l] + WXIP1'(lane_bit[l]);
      if (&cnt) state <= DONE;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_es_ordered_bs_mul_nch.sv
// tb_es_ordered_bs_mul_nch: randomized bench with a transaction-level product model and literal spot checks.
module tb_es_ordered_bs_mul_nch;
  localparam int DW = 5, NI = 2, NL = 4, CW = DW*NI, W = CW+1;
  logic clk = 0, rst = 1, en = 1, start = 0;
  logic bip = 0;
  logic [NL-1:0][NI-1:0][DW-1:0] din = '0;
  logic [NL-1:0][W-1:0] dout;
  logic busy, done;
  logic start2 = 0;
  logic [0:0][2:0][2:0] din2 = '0;
  logic [0:0][9:0] dout2;
  logic busy2, done2;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  int m_phase = 0, m_left = 0;
  int m_exp [NL];

  always #5 clk = ~clk;

  es_ordered_bs_mul_nch #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_LANES(NL)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
`ifdef ES_BS_BIPOLAR_EN
    .bipolar(bip),
`endif
    .bin_data_in(din), .bin_data_out(dout), .busy(busy), .done(done));

  es_ordered_bs_mul_nch #(.DATA_WIDTH(3), .NUM_INPUTS(3), .NUM_LANES(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .start(start2),
`ifdef ES_BS_BIPOLAR_EN
    .bipolar(1'b0),
`endif
    .bin_data_in(din2), .bin_data_out(dout2), .busy(busy2), .done(done2));

`ifdef ES_BS_BIPOLAR_EN
  logic start3 = 0, bip3 = 0;
  logic [0:0][1:0][2:0] din3 = '0;
  logic [0:0][6:0] dout3;
  logic busy3, done3;
  es_ordered_bs_mul_nch #(.DATA_WIDTH(3), .NUM_INPUTS(2), .NUM_LANES(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .start(start3), .bipolar(bip3),
    .bin_data_in(din3), .bin_data_out(dout3), .busy(busy3), .done(done3));
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Count of tuples giving a 1: unipolar = product; bipolar = tuples with an even number of ones.
  function automatic int model_lane(input logic [NI-1:0][DW-1:0] v, input bit bp);
    int n = 1 << DW;
    int prod = 1, e = 1, o = 0, t;
    for (int i = 0; i < NI; i++) begin
      prod *= int'(v[i]);
      t = e*(n - int'(v[i])) + o*int'(v[i]);
      o = o*(n - int'(v[i])) + e*int'(v[i]);
      e = t;
    end
    return bp ? e : prod;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_left = 0;
      for (int l = 0; l < NL; l++) m_exp[l] = 0;
    end else if (en) begin
      if (m_phase != 1 && start) begin
        m_phase = 1;
        m_left = 1 << CW;
        for (int l = 0; l < NL; l++) m_exp[l] = model_lane(din[l], bip);
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    check("busy", 32'(busy), 32'(m_phase == 1));
    check("done", 32'(done), 32'(m_phase == 2));
    if (m_phase != 1)
      for (int l = 0; l < NL; l++) check("out", 32'(dout[l]), m_phase == 2 ? m_exp[l] : 0);
  end

  function automatic logic [NL-1:0][NI-1:0][DW-1:0] rand_din();
    logic [NL-1:0][NI-1:0][DW-1:0] r;
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < NI; i++)
        r[l][i] = ($urandom % 4 == 0) ? (($urandom % 2) ? DW'(0) : {DW{1'b1}}) : DW'($urandom);
    return r;
  endfunction

  task automatic launch(input logic [NL-1:0][NI-1:0][DW-1:0] ops, input bit hold);
    @(negedge clk);
    din = ops;
    start = 1;
    @(negedge clk);
    start = hold;
  endtask

  task automatic wait_done(input int limit, input bit tog, input bit rnd_en, input bit rnd_din, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      if (tog) en = ~en;
      else if (rnd_en) en = ($urandom % 4) != 0;
      if (rnd_din) din = rand_din();
      @(negedge clk);
      cyc++;
    end
    en = 1;
    if (!done) check("timeout", 32'(done), 1);
  endtask

  initial begin
    int cyc;
    logic [NL-1:0][NI-1:0][DW-1:0] ops;
    repeat (2) @(negedge clk);
    rst = 0;
    chk_on = 1;
    check("rst_out0", 32'(dout[0]), 0);
    check("rst_busy", 32'(busy), 0);
    ops[0] = {5'd31, 5'd31}; ops[1] = {5'd17, 5'd0}; ops[2] = {5'd1, 5'd1}; ops[3] = {5'd2, 5'd16};
    launch(ops, 0);
    wait_done(1100, 0, 0, 0, cyc);
    check("cycles_1024", cyc, 1024);
    check("lane0_961", 32'(dout[0]), 961);
    check("lane1_0", 32'(dout[1]), 0);
    check("lane2_1", 32'(dout[2]), 1);
    check("lane3_32", 32'(dout[3]), 32);
    launch(ops, 0);
    wait_done(2200, 1, 0, 0, cyc);
    check("cycles_2048", cyc, 2048);
    check("toggle_lane0", 32'(dout[0]), 961);
    check("toggle_lane3", 32'(dout[3]), 32);
    launch(ops, 0);
    repeat (499) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_out0", 32'(dout[0]), 0);
    ops = '0;
    ops[0] = {5'd6, 5'd5};
    launch(ops, 0);
    wait_done(1100, 0, 0, 0, cyc);
    check("after_abort_30", 32'(dout[0]), 30);
    launch(rand_din(), 1);
    wait_done(1100, 0, 0, 1, cyc);
    check("hold_cycles", cyc, 1024);
    @(negedge clk);
    start = 0;
    check("relaunch_done", 32'(done), 0);
    check("relaunch_busy", 32'(busy), 1);
    wait_done(1100, 0, 0, 0, cyc);
    for (int k = 0; k < 8; k++) begin
`ifdef ES_BS_BIPOLAR_EN
      bip = 1'($urandom);
`endif
      launch(rand_din(), 0);
      wait_done(6000, 0, 1, 0, cyc);
    end
    bip = 0;
    @(negedge clk);
    din2[0] = {3'd3, 3'd5, 3'd7};
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    cyc = 0;
    while (!done2 && cyc < 600) begin @(negedge clk); cyc++; end
    check("n3_cycles_512", cyc, 512);
    check("n3_out_105", 32'(dout2[0]), 105);
`ifdef ES_BS_BIPOLAR_EN
    for (int b = 1; b >= 0; b--) begin
      @(negedge clk);
      din3[0] = {3'd3, 3'd5};
      bip3 = 1'(b);
      start3 = 1;
      @(negedge clk);
      start3 = 0;
      cyc = 0;
      while (!done3 && cyc < 100) begin @(negedge clk); cyc++; end
      check("bipolar_out", 32'(dout3[0]), b ? 30 : 15);
    end
`endif
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/es_ordered_bs_mul_nch.md
ES_ORDERED_BS_MUL_NCH -- requirements
Module: es_ordered_bs_mul_nch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, bits per binary operand.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, operands multiplied per lane (>=2).
REQ-003 SHALL have parameter NUM_LANES, default 4, independent multiplications sharing one sequence counter.
REQ-004 SHALL have parameter WXIP1, default DATA_WIDTH*NUM_INPUTS+1, result width per lane.
REQ-005 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst input 1: synchronous, active-high reset.
REQ-007 SHALL have port en input 1: clock enable; when low, all state holds.
REQ-008 SHALL have port start input 1: request to begin an operation.
REQ-009 SHALL have port bin_data_in input [NUM_LANES][NUM_INPUTS][DATA_WIDTH]: unsigned operands, sampled on accepted start.
REQ-010 SHALL have port bin_data_out output [NUM_LANES][WXIP1]: per-lane ones count, i.e. the product.
REQ-011 SHALL have port busy output 1: high in RUN.
REQ-012 SHALL have port done output 1: high in DONE, result valid.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DONE; transitions occur only on cycles with en=1.
REQ-014 IDLE or DONE with start=1: SHALL capture all operands, clear sequence counter and all accumulators, go to RUN.
REQ-015 start in RUN SHALL be ignored; captured operands SHALL not change during RUN.
REQ-016 Sequence counter SHALL be DATA_WIDTH*NUM_INPUTS bits wide, split into NUM_INPUTS digits; digit i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-017 Stream bit for operand i SHALL be (digit_i < x_i); the ordered digit nesting yields exact enumeration of all operand-bit tuples.
REQ-018 Lane output bit SHALL be the AND-reduction of its NUM_INPUTS stream bits (unipolar mode).
REQ-019 Each RUN cycle SHALL add the lane bit to its WXIP1-bit accumulator and increment the counter.
REQ-020 RUN SHALL last exactly 2^(DATA_WIDTH*NUM_INPUTS) enabled cycles; on counter wrap to zero SHALL enter DONE.
REQ-021 Final unipolar result SHALL equal product of the lane's x_i exactly; no saturation required.
REQ-022 done SHALL remain high and bin_data_out SHALL hold until the next accepted start.
REQ-023 bin_data_out SHALL show the live accumulator during RUN (not guaranteed meaningful).
REQ-024 en=0 mid-RUN SHALL freeze counter, accumulators and FSM; result SHALL be unaffected by pause length.

Reset
REQ-025 rst=1 SHALL force IDLE, counter=0, accumulators=0, busy=0, done=0, bin_data_out=0, regardless of en.
REQ-026 rst SHALL take priority over start; reset mid-RUN SHALL abort with no done pulse.

Configuration
REQ-027 Macro ES_BS_BIPOLAR_EN SHALL, when defined, add input port bipolar (1 bit), captured with operands on accepted start.
REQ-028 With macro and captured bipolar=1, lane bit SHALL be XNOR-reduction of stream bits; with bipolar=0, AND-reduction.
REQ-029 Without macro, no bipolar port SHALL exist and behaviour SHALL be unipolar only.

Verification
REQ-030 Defaults, rst then start with lane0={31,31}, lane1={0,17}, lane2={1,1}, lane3={16,2} -> done after 1024 enabled cycles; outputs 961, 0, 1, 32.
REQ-031 Same stimulus with en toggled 1/0 every cycle -> done after 2048 clocks; identical outputs.
REQ-032 rst asserted at RUN cycle 500 -> next cycle all outputs 0, IDLE; new start {5,6} -> result 30 after 1024 cycles.
REQ-033 start held high through RUN with changing bin_data_in -> ignored; result from first captured operands; start in DONE relaunches, done drops next cycle.
REQ-034 DATA_WIDTH=3, NUM_INPUTS=3, operands {7,5,3} -> done after 512 cycles, output 105.
REQ-035 ES_BS_BIPOLAR_EN, DATA_WIDTH=3, NUM_INPUTS=2, bipolar=1, {5,3} -> output 30 (5*3+3*5); bipolar=0 -> 15.
